// File: rtl/alu_seq.sv
// Multi-cycle ALU for the labcpu datapath. Single-cycle arithmetic, logic and
// shift ops finish in one cycle. Unsigned MUL and DIV run iteratively for W cycles.
// Results and flags are registered and announced by a one-cycle done pulse.
module alu_seq #(
  parameter int p_data_width   = 16,
  parameter int p_flags_width  = 5,
  parameter int p_opcode_width = 4,
  parameter int p_cnt_width    = $clog2(p_data_width + 1)
) (
  input  logic                      i_w_clk,
  input  logic                      i_w_reset,
  input  logic                      i_w_valid,
  output logic                      o_w_ready,
  input  logic [p_data_width-1:0]   i_w_in1,
  input  logic [p_data_width-1:0]   i_w_in2,
  input  logic [p_opcode_width-1:0] i_w_opcode,
  input  logic                      i_w_carry,
  input  logic                      i_w_oe,
  output logic [p_data_width-1:0]   o_w_out,
  output logic [p_data_width-1:0]   o_w_out_hi,
  output logic [p_flags_width-1:0]  o_w_flags,
  output logic                      o_w_done
);

  localparam int dw       = p_data_width;
  localparam int msb      = dw - 1;
  localparam int sh_width = $clog2(dw);

  typedef logic [p_opcode_width-1:0] opcode_t;
  localparam opcode_t op_adc  = opcode_t'(0);
  localparam opcode_t op_sbb1 = opcode_t'(1);
  localparam opcode_t op_sbb2 = opcode_t'(2);
  localparam opcode_t op_nor  = opcode_t'(3);
  localparam opcode_t op_and  = opcode_t'(4);
  localparam opcode_t op_or   = opcode_t'(5);
  localparam opcode_t op_xor  = opcode_t'(6);
  localparam opcode_t op_shl  = opcode_t'(7);
  localparam opcode_t op_shr  = opcode_t'(8);
  localparam opcode_t op_sar  = opcode_t'(9);
  localparam opcode_t op_mul  = opcode_t'(10);
  localparam opcode_t op_div  = opcode_t'(11);

  typedef enum logic {st_idle, st_run} state_t;

  // Flag vector {P,S,Z,O,C}; P/S/Z always describe the low result word.
  function automatic logic [p_flags_width-1:0] pack_flags(input logic [dw-1:0] res,
                                                          input logic ovf, input logic cy);
    logic [p_flags_width-1:0] f;
    f    = '0;
    f[4] = ~^res;
    f[3] = res[msb];
    f[2] = (res == '0);
    f[1] = ovf;
    f[0] = cy;
    return f;
  endfunction

  state_t               state_q, state_d;
  logic [p_cnt_width-1:0] cnt_q;
  logic [dw-1:0]        acc_q, mq_q, opb_q;
  logic                 is_div_q;
  logic [dw-1:0]        res_q, hi_q;
  logic [p_flags_width-1:0] flags_q;
  logic                 done_q;

  logic                 accept, is_long_op;
  logic [sh_width-1:0]  sh_amt;
  logic [dw:0]          add_w, sub1_w, sub2_w, shl_w, shr_w, sar_w;
  logic [dw-1:0]        alu_res;
  logic                 alu_c, alu_o;

  logic [dw:0]          mul_sum, div_shift, div_diff;
  logic [dw-1:0]        acc_nx, mq_nx;
  logic                 hi_nz, long_ovf, long_cy;

  assign o_w_ready  = (state_q == st_idle);
  assign accept     = i_w_valid & o_w_ready;
  assign is_long_op = (i_w_opcode == op_mul) | (i_w_opcode == op_div);

  // W+1-bit arithmetic so bit W is the carry/borrow out; shifts widened by one
  // bit so the last bit shifted out lands in the extra position.
  assign sh_amt = i_w_in2[sh_width-1:0];
  assign add_w  = {1'b0, i_w_in1} + {1'b0, i_w_in2} + {{dw{1'b0}}, i_w_carry};
  assign sub1_w = {1'b0, i_w_in1} - {1'b0, i_w_in2} - {{dw{1'b0}}, i_w_carry};
  assign sub2_w = {1'b0, i_w_in2} - {1'b0, i_w_in1} - {{dw{1'b0}}, i_w_carry};
  assign shl_w  = {1'b0, i_w_in1} << sh_amt;
  assign shr_w  = {i_w_in1, 1'b0} >> sh_amt;
  assign sar_w  = $signed({i_w_in1, 1'b0}) >>> sh_amt;

  // Single-cycle op result, carry and signed overflow.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    alu_res = '0;
    alu_c   = 1'b0;
    alu_o   = 1'b0;
    case (i_w_opcode)
      op_adc: begin
        alu_res = add_w[msb:0];
        alu_c   = add_w[dw];
        alu_o   = (i_w_in1[msb] == i_w_in2[msb]) & (alu_res[msb] != i_w_in1[msb]);
      end
      op_sbb1: begin
        alu_res = sub1_w[msb:0];
        alu_c   = sub1_w[dw];
        alu_o   = (i_w_in1[msb] != i_w_in2[msb]) & (alu_res[msb] != i_w_in1[msb]);
      end
      op_sbb2: begin
        alu_res = sub2_w[msb:0];
        alu_c   = sub2_w[dw];
        alu_o   = (i_w_in2[msb] != i_w_in1[msb]) & (alu_res[msb] != i_w_in2[msb]);
      end
      op_nor: alu_res = ~(i_w_in1 | i_w_in2);
      op_and: alu_res = i_w_in1 & i_w_in2;
      op_or:  alu_res = i_w_in1 | i_w_in2;
      op_xor: alu_res = i_w_in1 ^ i_w_in2;
      op_shl: begin
        alu_res = shl_w[msb:0];
        alu_c   = shl_w[dw];
        alu_o   = (sh_amt != '0) & (alu_res[msb] != alu_c);
      end
      op_shr: begin
        alu_res = shr_w[dw:1];
        alu_c   = shr_w[0];
        alu_o   = (sh_amt != '0) & i_w_in1[msb];
      end
      op_sar: begin
        alu_res = sar_w[dw:1];
        alu_c   = sar_w[0];
      end
      default: ;
    endcase
  end

  // One iteration step: shift-add for MUL ({acc,mq} = partial product, multiplier
  // drains from mq), restoring subtract for DIV (acc = remainder, mq = dividend/quotient).
  always_comb begin
    mul_sum   = {1'b0, acc_q} + {1'b0, (mq_q[0] ? opb_q : {dw{1'b0}})};
    div_shift = {acc_q, mq_q[msb]};
    div_diff  = div_shift - {1'b0, opb_q};
    if (is_div_q) begin
      if (!div_diff[dw]) begin
        acc_nx = div_diff[msb:0];
        mq_nx  = {mq_q[msb-1:0], 1'b1};
      end else begin
        acc_nx = div_shift[msb:0];
        mq_nx  = {mq_q[msb-1:0], 1'b0};
      end
    end else begin
      {acc_nx, mq_nx} = {mul_sum, mq_q[msb:1]};
    end
    hi_nz    = (acc_nx != '0);
    long_ovf = is_div_q ? (opb_q == '0) : hi_nz;
    long_cy  = is_div_q ? 1'b0 : hi_nz;
  end

  // FSM state register.
  always_ff @(posedge i_w_clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (i_w_reset) state_q <= st_idle;
    else           state_q <= state_d;
  end

  // FSM next state: long ops occupy RUN until the final iteration.
  always_comb begin
    state_d = state_q;
    case (state_q)
      st_idle: if (accept && is_long_op)       state_d = st_run;
      st_run:  if (cnt_q == p_cnt_width'(1))   state_d = st_idle;
      default:                                 state_d = st_idle;
    endcase
  end

  // Datapath: operand capture, iteration, result/flag registers and done pulse.
  always_ff @(posedge i_w_clk) begin
    if (i_w_reset) begin
      cnt_q    <= '0;
      acc_q    <= '0;
      mq_q     <= '0;
      opb_q    <= '0;
      is_div_q <= 1'b0;
      res_q    <= '0;
      hi_q     <= '0;
      flags_q  <= '0;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (accept) begin
        if (is_long_op) begin
          acc_q    <= '0;
          mq_q     <= i_w_in1;
          opb_q    <= i_w_in2;
          is_div_q <= (i_w_opcode == op_div);
          cnt_q    <= p_cnt_width'(dw);
        end else begin
          res_q   <= alu_res;
          hi_q    <= '0;
          flags_q <= pack_flags(alu_res, alu_o, alu_c);
          done_q  <= 1'b1;
        end
      end else if (state_q == st_run) begin
        acc_q <= acc_nx;
        mq_q  <= mq_nx;
        cnt_q <= cnt_q - p_cnt_width'(1);
        if (cnt_q == p_cnt_width'(1)) begin
          res_q   <= mq_nx;
          hi_q    <= acc_nx;
          flags_q <= pack_flags(mq_nx, long_ovf, long_cy);
          done_q  <= 1'b1;
        end
      end
    end
  end

  assign o_w_out    = i_w_oe ? res_q : '0;
  assign o_w_out_hi = i_w_oe ? hi_q  : '0;
  assign o_w_flags  = flags_q;
  assign o_w_done   = done_q;

endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq (W=16): directed corner cases plus random ops
// compared against an arithmetic reference model.
module tb_alu_seq;

  localparam int W = 16;

  logic        i_w_clk;
  logic        i_w_reset;
  logic        i_w_valid;
  logic        o_w_ready;
  logic [15:0] i_w_in1;
  logic [15:0] i_w_in2;
  logic [3:0]  i_w_opcode;
  logic        i_w_carry;
  logic        i_w_oe;
  logic [15:0] o_w_out;
  logic [15:0] o_w_out_hi;
  logic [4:0]  o_w_flags;
  logic        o_w_done;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct packed {
    logic [15:0] out;
    logic [15:0] hi;
    logic [4:0]  flags;
  } exp_t;

  alu_seq #(.p_data_width(16)) dut (
    .i_w_clk    (i_w_clk),
    .i_w_reset  (i_w_reset),
    .i_w_valid  (i_w_valid),
    .o_w_ready  (o_w_ready),
    .i_w_in1    (i_w_in1),
    .i_w_in2    (i_w_in2),
    .i_w_opcode (i_w_opcode),
    .i_w_carry  (i_w_carry),
    .i_w_oe     (i_w_oe),
    .o_w_out    (o_w_out),
    .o_w_out_hi (o_w_out_hi),
    .o_w_flags  (o_w_flags),
    .o_w_done   (o_w_done)
  );

  initial i_w_clk = 1'b0;
  always #5 i_w_clk = ~i_w_clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  function automatic bit is_long(input logic [3:0] op);
    return (op == 4'd10) || (op == 4'd11);
  endfunction

  // Reference model: plain integer arithmetic on the operand values.
  function automatic exp_t ref_model(input logic [3:0] op, input logic [15:0] a,
                                     input logic [15:0] b, input logic cin);
    exp_t        e;
    int unsigned n;
    int          sa, sb, sr;
    longint      full;
    logic        c, o;
    logic [15:0] r, h;
    n  = b[3:0];
    sa = int'($signed(a));
    sb = int'($signed(b));
    r = '0; h = '0; c = 1'b0; o = 1'b0;
    case (op)
      4'd0: begin
        full = longint'(a) + longint'(b) + longint'(cin);
        r = full[15:0]; c = (full > 65535);
        sr = sa + sb + int'(cin); o = (sr > 32767) || (sr < -32768);
      end
      4'd1: begin
        full = longint'(a) - longint'(b) - longint'(cin);
        r = full[15:0]; c = (full < 0);
        sr = sa - sb - int'(cin); o = (sr > 32767) || (sr < -32768);
      end
      4'd2: begin
        full = longint'(b) - longint'(a) - longint'(cin);
        r = full[15:0]; c = (full < 0);
        sr = sb - sa - int'(cin); o = (sr > 32767) || (sr < -32768);
      end
      4'd3: r = ~(a | b);
      4'd4: r = a & b;
      4'd5: r = a | b;
      4'd6: r = a ^ b;
      4'd7: begin
        full = longint'(a) << n;
        r = full[15:0];
        c = (n != 0) && full[16];
        o = (n != 0) && (r[15] != c);
      end
      4'd8: begin
        r = a >> n;
        c = (n != 0) ? a[n-1] : 1'b0;
        o = (n != 0) && a[15];
      end
      4'd9: begin
        sr = sa >>> n;
        r = sr[15:0];
        c = (n != 0) ? a[n-1] : 1'b0;
      end
      4'd10: begin
        full = longint'(a) * longint'(b);
        r = full[15:0]; h = full[31:16];
        c = (h != 0); o = c;
      end
      4'd11: begin
        if (b == 0) begin
          r = 16'hFFFF; h = a; o = 1'b1;
        end else begin
          r = a / b; h = a % b;
        end
      end
      default: ;
    endcase
    e.out   = r;
    e.hi    = h;
    e.flags = {~^r, r[15], (r == 16'h0), o, c};
    return e;
  endfunction

  task automatic drive(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                       input logic cin);
    i_w_opcode = op;
    i_w_in1    = a;
    i_w_in2    = b;
    i_w_carry  = cin;
  endtask

  // Issue one op, wait for its done pulse, check latency, busy window, results.
  task automatic run_op(input string tag, input logic [3:0] op, input logic [15:0] a,
                        input logic [15:0] b, input logic cin, input logic oe);
    exp_t e;
    int   lat, wait_cnt;
    bit   early_ready;
    e = ref_model(op, a, b, cin);
    drive(op, a, b, cin);
    i_w_oe    = oe;
    i_w_valid = 1'b1;
    wait_cnt  = 0;
    while (!o_w_ready && wait_cnt < 100) begin
      @(posedge i_w_clk); #1;
      wait_cnt++;
    end
    if (!o_w_ready) begin
      check({tag, " ready_timeout"}, 64'd0, 64'd1);
      i_w_valid = 1'b0;
      return;
    end
    @(posedge i_w_clk); #1;
    i_w_valid   = 1'b0;
    lat         = 1;
    early_ready = 1'b0;
    while (!o_w_done && lat < 100) begin
      if (o_w_ready) early_ready = 1'b1;
      @(posedge i_w_clk); #1;
      lat++;
    end
    check({tag, " latency"}, lat, is_long(op) ? W + 1 : 1);
    if (is_long(op)) check({tag, " ready_low_while_busy"}, early_ready, 1'b0);
    check({tag, " ready_at_done"}, o_w_ready, 1'b1);
    check({tag, " out"},   o_w_out,    oe ? e.out : 16'h0);
    check({tag, " hi"},    o_w_out_hi, oe ? e.hi  : 16'h0);
    check({tag, " flags"}, o_w_flags,  e.flags);
    @(posedge i_w_clk); #1;
    check({tag, " done_pulse_width"}, o_w_done, 1'b0);
  endtask

  function automatic logic [3:0] pick_short();
    logic [3:0] op;
    op = 4'($urandom_range(0, 13));
    if (op >= 4'd10) op = op + 4'd2;
    return op;
  endfunction

  initial begin
    exp_t        e, prev;
    logic [3:0]  op;
    logic [15:0] a, b;
    logic        cin;
    int          dones, lat;

    i_w_reset = 1'b1;
    i_w_valid = 1'b0;
    i_w_oe    = 1'b1;
    drive(4'd0, 16'h0, 16'h0, 1'b0);

    // Power-on reset.
    repeat (3) @(posedge i_w_clk);
    #1 i_w_reset = 1'b0;
    check("por ready", o_w_ready, 1'b1);
    check("por done",  o_w_done,  1'b0);
    check("por out",   o_w_out,   16'h0);
    check("por flags", o_w_flags, 5'h0);

    // Reset held 3 cycles during a MUL in RUN aborts it without a done pulse.
    drive(4'd10, 16'h1234, 16'h0100, 1'b0);
    i_w_valid = 1'b1;
    @(posedge i_w_clk); #1;
    i_w_valid = 1'b0;
    check("abort busy", o_w_ready, 1'b0);
    repeat (4) @(posedge i_w_clk);
    #1 i_w_reset = 1'b1;
    repeat (3) @(posedge i_w_clk);
    #1 i_w_reset = 1'b0;
    check("abort ready", o_w_ready,  1'b1);
    check("abort done",  o_w_done,   1'b0);
    check("abort out",   o_w_out,    16'h0);
    check("abort hi",    o_w_out_hi, 16'h0);
    check("abort flags", o_w_flags,  5'h0);
    dones = 0;
    repeat (20) begin
      @(posedge i_w_clk); #1;
      if (o_w_done) dones++;
    end
    check("abort no_done", dones, 0);

    // Directed corner cases, with fixed expected values alongside the model.
    run_op("adc_ovf", 4'd0, 16'h7FFF, 16'h0001, 1'b0, 1'b1);
    check("adc_ovf out_k",   o_w_out,   16'h8000);
    check("adc_ovf flags_k", o_w_flags, 5'b01010);
    run_op("mul", 4'd10, 16'h1234, 16'h0100, 1'b0, 1'b1);
    check("mul out_k", o_w_out,        16'h3400);
    check("mul hi_k",  o_w_out_hi,     16'h0012);
    check("mul oc_k",  o_w_flags[1:0], 2'b11);
    run_op("div", 4'd11, 16'd100, 16'd7, 1'b0, 1'b1);
    check("div out_k", o_w_out,      16'h000E);
    check("div hi_k",  o_w_out_hi,   16'h0002);
    check("div o_k",   o_w_flags[1], 1'b0);
    run_op("div0", 4'd11, 16'd5, 16'd0, 1'b0, 1'b1);
    check("div0 out_k", o_w_out,      16'hFFFF);
    check("div0 hi_k",  o_w_out_hi,   16'h0005);
    check("div0 o_k",   o_w_flags[1], 1'b1);
    run_op("shl", 4'd7, 16'h8001, 16'h0004, 1'b0, 1'b1);
    check("shl out_k", o_w_out,      16'h0010);
    check("shl c_k",   o_w_flags[0], 1'b0);
    run_op("sar", 4'd9, 16'h8000, 16'h0003, 1'b0, 1'b1);
    check("sar out_k", o_w_out,      16'hF000);
    check("sar s_k",   o_w_flags[3], 1'b1);
    check("sar c_k",   o_w_flags[0], 1'b0);
    run_op("shr_n0", 4'd8, 16'hA5A5, 16'hFFF0, 1'b1, 1'b1);
    run_op("shl_n15", 4'd7, 16'h0003, 16'h000F, 1'b0, 1'b1);
    run_op("sbb1_borrow", 4'd1, 16'h0000, 16'h0000, 1'b1, 1'b1);
    run_op("undef", 4'd13, 16'hFFFF, 16'hFFFF, 1'b1, 1'b1);

    // Output enable low gates out/hi but not flags; raising it reveals held results.
    e = ref_model(4'd10, 16'hBEEF, 16'h1357, 1'b0);
    run_op("oe0", 4'd10, 16'hBEEF, 16'h1357, 1'b0, 1'b0);
    i_w_oe = 1'b1;
    #1;
    check("oe1 out", o_w_out,    e.out);
    check("oe1 hi",  o_w_out_hi, e.hi);

    // Back-to-back single-cycle ops: one done per cycle.
    op = pick_short(); a = 16'($urandom); b = 16'($urandom); cin = 1'($urandom);
    drive(op, a, b, cin);
    prev = ref_model(op, a, b, cin);
    i_w_valid = 1'b1;
    for (int k = 0; k < 8; k++) begin
      @(posedge i_w_clk); #1;
      check("b2b done",  o_w_done,  1'b1);
      check("b2b out",   o_w_out,   prev.out);
      check("b2b flags", o_w_flags, prev.flags);
      op = pick_short(); a = 16'($urandom); b = 16'($urandom); cin = 1'($urandom);
      drive(op, a, b, cin);
      prev = ref_model(op, a, b, cin);
    end
    @(posedge i_w_clk); #1;
    i_w_valid = 1'b0;
    check("b2b last_done", o_w_done, 1'b1);
    check("b2b last_out",  o_w_out,  prev.out);
    @(posedge i_w_clk); #1;

    // Valid held through a DIV with a different op: that op is taken at the done cycle.
    drive(4'd11, 16'd1000, 16'd33, 1'b0);
    i_w_valid = 1'b1;
    @(posedge i_w_clk); #1;
    drive(4'd0, 16'h1111, 16'h2222, 1'b1);
    lat = 1;
    while (!o_w_done && lat < 100) begin
      @(posedge i_w_clk); #1;
      lat++;
    end
    check("hold latency", lat, W + 1);
    check("hold div_out", o_w_out,    16'd30);
    check("hold div_hi",  o_w_out_hi, 16'd10);
    @(posedge i_w_clk); #1;
    i_w_valid = 1'b0;
    check("hold adc_done", o_w_done, 1'b1);
    check("hold adc_out",  o_w_out,  16'h3334);
    @(posedge i_w_clk); #1;

    // Random ops against the reference model.
    for (int k = 0; k < 150; k++) begin
      int sel;
      op  = 4'($urandom_range(0, 15));
      a   = 16'($urandom);
      b   = 16'($urandom);
      cin = 1'($urandom);
      sel = $urandom_range(0, 7);
      if (sel == 0)      b[3:0] = 4'h0;
      else if (sel == 1) b[3:0] = 4'hF;
      else if (sel == 2) b = 16'h0;
      run_op($sformatf("rnd%0d op%0d", k, op), op, a, b, cin, 1'($urandom_range(0, 7) != 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
